// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: NOP encoding, fetch FSM state codes and the
// default reset PC used by the fetch stage and the pipeline stage registers.
package fetch_stage_pkg;

   // addi x0, x0, 0 -- the canonical RISC-V NOP, used for every bubble
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

   // Fetch FSM state codes
   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t ST_IDLE  = 2'd0;  // nothing outstanding
   localparam fetch_state_t ST_WAIT  = 2'd1;  // request outstanding
   localparam fetch_state_t ST_FULL  = 2'd2;  // word parked in the 1-entry buffer
   localparam fetch_state_t ST_DRAIN = 2'd3;  // request outstanding, already squashed

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// Generic pc/instr/valid pipeline register with load, flush-to-bubble and
// synchronous reset; reusable for later stage registers.
module if_id_register
   import fetch_stage_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            load,
   input  logic            flush,
   input  logic            load_valid,
   input  logic [XLEN-1:0] load_pc,
   input  logic [31:0]     load_instr,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     instr,
   output logic            valid
);

   // Flush beats load; a load without a real word inserts a bubble
   always_ff @(posedge clock) begin
      if (reset) begin
         pc    <= '0;
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (flush) begin
         pc    <= load_pc;
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (load) begin
         pc    <= load_pc;
         instr <= load_valid ? load_instr : NOP_INSTR;
         valid <= load_valid;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake,
// 1-entry decode-stall buffer, redirect/squash handling and the IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            pc_load,
   input  logic            if_id_load,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [31:0]     imem_rdata,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_instr,
   output logic            if_id_valid
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt, addr_nxt, pc_plus4;
   logic [31:0]     buf_instr, buf_nxt, word;
   logic            deliver, flush;

   assign pc_plus4 = pc + PC_STEP;  // wraps modulo 2^XLEN
   assign imem_req = (state == ST_WAIT) || (state == ST_DRAIN);

   // Next-state, next-PC, fetch address and IF/ID load decisions
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_nxt = state;
      pc_nxt    = pc;
      addr_nxt  = imem_addr;
      buf_nxt   = buf_instr;
      word      = buf_instr;
      deliver   = 1'b0;
      flush     = 1'b0;
      if (branch_taken) begin
         // Redirect wins: flush IF/ID, drop the buffer, squash any request
         pc_nxt = branch_target;
         flush  = 1'b1;
         if ((state == ST_WAIT || state == ST_DRAIN) && !imem_valid)
            state_nxt = ST_DRAIN;
         else
            state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pc_load) begin
                  state_nxt = ST_WAIT;
                  addr_nxt  = pc;
               end
            end
            ST_WAIT: begin
               if (imem_valid && if_id_load) begin
                  deliver   = 1'b1;
                  word      = imem_rdata;
                  pc_nxt    = pc_plus4;
                  state_nxt = pc_load ? ST_WAIT : ST_IDLE;
                  if (pc_load) addr_nxt = pc_plus4;
               end else if (imem_valid) begin
                  buf_nxt   = imem_rdata;
                  state_nxt = ST_FULL;
               end
            end
            ST_FULL: begin
               if (if_id_load) begin
                  deliver   = 1'b1;
                  pc_nxt    = pc_plus4;
                  state_nxt = pc_load ? ST_WAIT : ST_IDLE;
                  if (pc_load) addr_nxt = pc_plus4;
               end
            end
            ST_DRAIN: begin
               if (imem_valid) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State, PC and fetch-address registers
   always_ff @(posedge clock) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples the pre-edge values of its neighbours.
      if (reset) begin
         state     <= ST_IDLE;
         pc        <= RESET_PC;
         imem_addr <= RESET_PC;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         imem_addr <= addr_nxt;
      end
   end

   // Buffer data register; whether it holds a word is tracked by ST_FULL
   always_ff @(posedge clock) begin
      // NOTE: the buffer payload is deliberately not reset: its validity lives
      // in the state register, so resetting the data would buy nothing.
      buf_instr <= buf_nxt;
   end

   if_id_register #(.XLEN(XLEN)) u_if_id (
      .clock      (clock),
      .reset      (reset),
      .load       (if_id_load),
      .flush      (flush),
      .load_valid (deliver),
      .load_pc    (pc),
      .load_instr (word),
      .pc         (if_id_pc),
      .instr      (if_id_instr),
      .valid      (if_id_valid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, two multi-cycle
// corner-case sequences, and randomized traffic against a behavioural model.
module tb_fetch_stage;

   localparam logic [63:0] RST_PC = 64'h100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset, pc_load, if_id_load, branch_taken;
   logic [63:0] branch_target;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic [63:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;

   fetch_stage #(.XLEN(64), .RESET_PC(RST_PC)) dut (
      .clock(clock), .reset(reset), .pc_load(pc_load), .if_id_load(if_id_load),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
      .imem_rdata(imem_rdata), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
      .if_id_valid(if_id_valid)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        req;
      logic [63:0] addr;
      logic [63:0] pc;
      logic [31:0] instr;
      logic        valid;
   } out_t;

   typedef struct {
      logic        rst, pcl, ifl, br;
      logic [63:0] tgt;
      logic        vld;
      logic [31:0] rdata;
      out_t        exp;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [31:0] word_of(input logic [63:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   function automatic out_t dut_out();
      return '{req: imem_req, addr: imem_addr, pc: if_id_pc,
               instr: if_id_instr, valid: if_id_valid};
   endfunction

   task automatic check(input string name, input out_t act, input out_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got req=%0b addr=%h pc=%h instr=%h v=%0b, want req=%0b addr=%h pc=%h instr=%h v=%0b",
                  name, act.req, act.addr, act.pc, act.instr, act.valid,
                  exp.req, exp.addr, exp.pc, exp.instr, exp.valid);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0b, want %0b", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [63:0] m_pc, m_addr;
   logic        m_req, m_squashed;
   logic [31:0] m_held[$];
   out_t        m_ifid;   // only pc/instr/valid fields used

   task automatic model_update();
      logic [31:0] w;
      bit avail, delivered, was_idle;
      if (reset) begin
         m_pc = RST_PC; m_addr = RST_PC; m_req = 0; m_squashed = 0;
         m_held.delete();
         m_ifid = '{req: 0, addr: 0, pc: 64'h0, instr: NOP, valid: 0};
         return;
      end
      was_idle = !m_req && (m_held.size() == 0);
      if (branch_taken) begin
         m_ifid.pc = m_pc; m_ifid.instr = NOP; m_ifid.valid = 0;
         m_held.delete();
         m_pc = branch_target;
         if (m_req && !imem_valid) m_squashed = 1;
         else begin m_req = 0; m_squashed = 0; end
         return;
      end
      avail = 0; delivered = 0; w = NOP;
      if (m_held.size() > 0) begin avail = 1; w = m_held[0]; end
      else if (m_req && imem_valid && !m_squashed) begin avail = 1; w = imem_rdata; end
      if (m_req && imem_valid) begin m_req = 0; m_squashed = 0; end
      if (avail && if_id_load) begin
         delivered = 1;
         m_ifid.pc = m_pc; m_ifid.instr = w; m_ifid.valid = 1;
         m_held.delete();
         m_pc = m_pc + 64'd4;
      end else if (avail) begin
         if (m_held.size() == 0) m_held.push_back(w);
      end else if (if_id_load) begin
         m_ifid.pc = m_pc; m_ifid.instr = NOP; m_ifid.valid = 0;
      end
      if (pc_load && (was_idle || delivered)) begin m_req = 1; m_addr = m_pc; end
   endtask

   function automatic out_t model_out();
      return '{req: m_req, addr: m_addr, pc: m_ifid.pc,
               instr: m_ifid.instr, valid: m_ifid.valid};
   endfunction

   // ---------------- instruction-memory responder ----------------
   bit          busy = 0, lat_rand = 0;
   int          lat_left = 0, lat_default = 0, slow_lat = 0, n_start_100 = 0;
   logic [63:0] slow_addr = '1;

   task automatic drive_mem();
      if (imem_req === 1'b1) begin
         if (!busy) begin
            busy = 1;
            if (lat_rand) lat_left = int'($urandom_range(0, 3));
            else lat_left = (imem_addr == slow_addr) ? slow_lat : lat_default;
            if (imem_addr == 64'h100) n_start_100++;
         end
         imem_valid = (lat_left == 0);
         imem_rdata = imem_valid ? word_of(imem_addr) : $urandom;
      end else begin
         busy = 0; imem_valid = 0; imem_rdata = $urandom;
      end
   endtask

   // One clock: model and responder advance on the edge, outputs sampled #1 later
   task automatic step();
      @(posedge clock);
      model_update();
      if (reset || imem_valid) busy = 0;
      else if (busy) lat_left--;
      #1;
   endtask

   task automatic do_reset();
      reset = 1; pc_load = 0; if_id_load = 0; branch_taken = 0; imem_valid = 0;
      step(); step();
      check("reset", dut_out(), model_out());
      reset = 0;
   endtask

   vec_t tbl[13];
   bit   saw_10c;

   initial begin
      reset = 1; pc_load = 0; if_id_load = 0; branch_taken = 0;
      branch_target = '0; imem_valid = 0; imem_rdata = '0;

      // ---- directed table: reset, stall-free fetch, redirect+valid, pc_load low, reset mid-request
      //             rst pcl ifl br tgt      vld rdata                 {req addr pc instr valid}
      tbl[0]  = '{1, 0, 0, 0, 64'h0,   0, 32'h0,              '{0, 64'h100, 64'h0,   NOP,               0}};
      tbl[1]  = '{0, 1, 1, 0, 64'h0,   0, 32'h0,              '{1, 64'h100, 64'h100, NOP,               0}};
      tbl[2]  = '{0, 1, 1, 0, 64'h0,   1, word_of(64'h100),   '{1, 64'h104, 64'h100, word_of(64'h100),  1}};
      tbl[3]  = '{0, 1, 1, 0, 64'h0,   1, word_of(64'h104),   '{1, 64'h108, 64'h104, word_of(64'h104),  1}};
      tbl[4]  = '{0, 1, 1, 0, 64'h0,   1, word_of(64'h108),   '{1, 64'h10C, 64'h108, word_of(64'h108),  1}};
      tbl[5]  = '{0, 1, 1, 1, 64'h200, 1, word_of(64'h10C),   '{0, 64'h10C, 64'h10C, NOP,               0}};
      tbl[6]  = '{0, 1, 1, 0, 64'h0,   0, 32'h0,              '{1, 64'h200, 64'h200, NOP,               0}};
      tbl[7]  = '{0, 1, 1, 0, 64'h0,   1, word_of(64'h200),   '{1, 64'h204, 64'h200, word_of(64'h200),  1}};
      tbl[8]  = '{0, 0, 1, 0, 64'h0,   1, word_of(64'h204),   '{0, 64'h204, 64'h204, word_of(64'h204),  1}};
      tbl[9]  = '{0, 0, 1, 0, 64'h0,   0, 32'h0,              '{0, 64'h204, 64'h208, NOP,               0}};
      tbl[10] = '{0, 1, 1, 0, 64'h0,   0, 32'h0,              '{1, 64'h208, 64'h208, NOP,               0}};
      tbl[11] = '{1, 1, 1, 0, 64'h0,   0, 32'h0,              '{0, 64'h100, 64'h0,   NOP,               0}};
      tbl[12] = '{0, 1, 1, 0, 64'h0,   0, 32'h0,              '{1, 64'h100, 64'h100, NOP,               0}};
      #1;
      for (int i = 0; i < 13; i++) begin
         reset = tbl[i].rst; pc_load = tbl[i].pcl; if_id_load = tbl[i].ifl;
         branch_taken = tbl[i].br; branch_target = tbl[i].tgt;
         imem_valid = tbl[i].vld; imem_rdata = tbl[i].rdata;
         step();
         check($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
      end

      // ---- decode stall: 3-cycle memory, response lands while if_id_load=0
      lat_rand = 0; lat_default = 3; slow_addr = '1;
      do_reset();
      n_start_100 = 0;
      pc_load = 1; if_id_load = 1;
      begin
         bit got = 0;
         for (int c = 0; c < 20 && !got; c++) begin
            drive_mem();
            if (imem_valid) got = 1;
            else begin step(); check("stall_wait", dut_out(), model_out()); end
         end
         if (!got) begin n_vec++; n_err++; $display("FAIL stall_timeout: no imem response"); end
      end
      if_id_load = 0;
      step();                                    // valid cycle: word goes to buffer
      check("stall_full", dut_out(), model_out());
      check_bit("stall_hold_valid", if_id_valid, 1'b0);
      drive_mem();
      step();                                    // second stalled cycle in FULL
      check("stall_full2", dut_out(), model_out());
      check_bit("stall_no_req", imem_req, 1'b0);
      if_id_load = 1;
      drive_mem();
      step();
      check("stall_release", dut_out(),
            '{req: 1, addr: 64'h104, pc: 64'h100, instr: word_of(64'h100), valid: 1});
      check("stall_release_model", dut_out(), model_out());
      check_bit("stall_no_refetch", n_start_100 == 1, 1'b1);

      // ---- redirect while WAIT on 0x10C, response 2 cycles later
      lat_default = 0; slow_addr = 64'h10C; slow_lat = 2;
      do_reset();
      saw_10c = 0;
      pc_load = 1; if_id_load = 1;
      begin
         bit found = 0;
         for (int c = 0; c < 20 && !found; c++) begin
            drive_mem();
            if (imem_req && imem_addr == 64'h10C) found = 1;
            else begin
               step();
               check("drain_run", dut_out(), model_out());
            end
         end
         if (!found) begin n_vec++; n_err++; $display("FAIL drain_timeout: 0x10C never requested"); end
      end
      branch_taken = 1; branch_target = 64'h200;
      step();
      branch_taken = 0;
      check("drain_enter", dut_out(), model_out());
      check_bit("drain_req", imem_req, 1'b1);
      for (int c = 0; c < 2; c++) begin          // c=1 carries the discarded valid
         drive_mem();
         if (if_id_valid && if_id_pc == 64'h10C) saw_10c = 1;
         step();
         check("drain_hold", dut_out(), model_out());
      end
      check_bit("drain_idle", imem_req, 1'b0);
      drive_mem();
      step();
      check("drain_refetch", dut_out(),
            '{req: 1, addr: 64'h200, pc: 64'h200, instr: NOP, valid: 0});
      for (int c = 0; c < 4; c++) begin
         drive_mem();
         step();
         if (if_id_valid && if_id_pc == 64'h10C) saw_10c = 1;
         check("drain_after", dut_out(), model_out());
      end
      check_bit("drain_10c_squashed", saw_10c, 1'b0);

      // ---- randomized traffic against the model
      lat_rand = 1;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         reset        = ($urandom_range(0, 99) == 0);
         pc_load      = ($urandom_range(0, 3) != 0);
         if_id_load   = ($urandom_range(0, 3) != 0);
         branch_taken = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) == 0) branch_target = 64'hFFFF_FFFF_FFFF_FFF8;
         else branch_target = {$urandom, $urandom} & ~64'h3;
         drive_mem();
         step();
         check($sformatf("random[%0d]", c), dut_out(), model_out());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
